uart_tx: RTL and testbench

- UART transmitter. Serializes one byte per frame onto tx_o: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Bit period is runtime-programmable in clock cycles through baud_div, with the same meaning as on uart_rx (868 = 115200 baud at 100 MHz).
- Sits between a byte producer (FIFO or register block) and the pad.
- tx_o connects directly to the rx_i of a uart_rx in loopback.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, parity modes and transmitter states.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BAUD_W    = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit timer: counts 0..B-1 and flags the last cycle of each bit; div of 0 acts as 1.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear,
    input  logic [BAUD_W-1:0] div,
    output logic              bit_end
);

    logic [BAUD_W-1:0] timer;
    logic [BAUD_W-1:0] last;

    assign last    = (div == '0) ? '0 : div - BAUD_W'(1);
    assign bit_end = (timer == last);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            timer <= '0;
        end else if (bit_end) begin
            timer <= '0;
        end else begin
            timer <= timer + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY = PAR_NONE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BAUD_W-1:0]    baud_div,
    input  logic                 two_stop_i,
    input  logic [DATA_BITS-1:0] din_i,
    input  logic                 tx_start_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_tick_o
);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 two_stop_q;
    logic                 par_q;
    logic [BAUD_W-1:0]    div_q;
    logic                 bit_end;
    logic                 last_stop;
    logic                 accept;
    logic                 tx_next;

    uart_baud_cnt u_baud (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state == IDLE),
        .div     (div_q),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) begin
                    state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: if (bit_end) state_next = STOP;
            STOP: begin
                if (last_stop) state_next = accept ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_stop      = (state == STOP) && bit_end && (!two_stop_q || stop_cnt);
        tx_ready_o     = (state == IDLE) || last_stop;
        accept         = tx_start_i && tx_ready_o;
        tx_busy_o      = (state != IDLE);
        tx_done_tick_o = last_stop;
    end

    // tx_o is registered, so its next value is derived from the next state and next shift contents.
    always_comb begin
        shreg_next = shreg;
        if (accept) begin
            shreg_next = din_i;
        end else if (state == DATA && bit_end) begin
            shreg_next = shreg >> 1;
        end
        case (state_next)
            IDLE:             tx_next = 1'b1;
            START:            tx_next = 1'b0;
            DATA:             tx_next = shreg_next[0];
            uart_pkg::PARITY: tx_next = par_q;
            default:          tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            two_stop_q <= 1'b0;
            par_q      <= 1'b0;
            div_q      <= '0;
            tx_o       <= 1'b1;
        end else begin
            shreg <= shreg_next;
            tx_o  <= tx_next;
            if (accept) begin
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                two_stop_q <= two_stop_i;
                par_q      <= parity_bit(din_i, PARITY);
                div_q      <= baud_div;
            end else begin
                if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
                if (state == STOP && bit_end) stop_cnt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: no-parity and odd-parity instances checked cycle by cycle.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        two_stop;
    logic [7:0]  din;
    logic        start0, start1;
    logic        ready0, ready1;
    logic        tx0, tx1;
    logic        busy0, busy1;
    logic        done0, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.PARITY(0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .baud_div       (baud_div),
        .two_stop_i     (two_stop),
        .din_i          (din),
        .tx_start_i     (start0),
        .tx_ready_o     (ready0),
        .tx_o           (tx0),
        .tx_busy_o      (busy0),
        .tx_done_tick_o (done0)
    );

    uart_tx #(.PARITY(2)) dut_par (
        .clk_i          (clk),
        .rst_i          (rst),
        .baud_div       (baud_div),
        .two_stop_i     (two_stop),
        .din_i          (din),
        .tx_start_i     (start1),
        .tx_ready_o     (ready1),
        .tx_o           (tx1),
        .tx_busy_o      (busy1),
        .tx_done_tick_o (done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int par);
        @(negedge clk);
        chk("idle_tx",    (par != 0) ? tx1    : tx0,    1);
        chk("idle_busy",  (par != 0) ? busy1  : busy0,  0);
        chk("idle_ready", (par != 0) ? ready1 : ready0, 1);
        chk("idle_done",  (par != 0) ? done1  : done0,  0);
    endtask

    // Called at a negedge where the selected instance is ready; returns at the negedge of the done-tick cycle.
    task automatic frame(input logic [7:0] d, input logic [15:0] div, input logic ts,
                         input int par, input int mid_k);
        logic lv [0:12];
        int   nb, b, n, idx;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = d[i];
        idx = 9;
        if (par != 0) begin
            lv[9] = (par == 1) ? ^d : ~^d;
            idx = 10;
        end
        lv[idx]   = 1'b1;
        lv[idx+1] = 1'b1;
        nb = 10 + ((par != 0) ? 1 : 0) + (ts ? 1 : 0);
        b  = (div == 16'd0) ? 1 : int'(div);
        n  = nb * b;
        din      = d;
        baud_div = div;
        two_stop = ts;
        chk("ready_acc", (par != 0) ? ready1 : ready0, 1);
        if (par != 0) start1 = 1'b1; else start0 = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start0   = 1'b0;
                start1   = 1'b0;
                din      = ~d;
                baud_div = div + 16'd3;
                two_stop = ~ts;
            end
            if (mid_k != 0 && k == mid_k) begin
                chk("ready_mid", (par != 0) ? ready1 : ready0, 0);
                din = 8'hFF;
                if (par != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            if (mid_k != 0 && k == mid_k + 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            chk("tx",   (par != 0) ? tx1   : tx0,   lv[(k-1)/b]);
            chk("done", (par != 0) ? done1 : done0, (k == n) ? 1 : 0);
            chk("busy", (par != 0) ? busy1 : busy0, 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        baud_div = 16'd0;
        two_stop = 1'b0;
        din      = 8'h00;
        start0   = 1'b0;
        start1   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",     tx0,    1);
        chk("rst_busy",   busy0,  0);
        chk("rst_ready",  ready0, 1);
        chk("rst_done",   done0,  0);
        chk("rst_tx_p",   tx1,    1);
        chk("rst_busy_p", busy1,  0);
        rst = 1'b0;
        idle_check(0);
        idle_check(2);

        frame(8'hA5, 16'd868, 1'b0, 0, 0);
        idle_check(0);

        frame(8'h3C, 16'd16, 1'b0, 0, 0);
        idle_check(0);
        frame(8'h00, 16'd16, 1'b0, 0, 0);
        idle_check(0);
        frame(8'hFF, 16'd16, 1'b1, 0, 0);
        idle_check(0);
        for (int r = 0; r < 20; r++) begin
            frame(8'($urandom_range(0, 255)), 16'd16, 1'($urandom_range(0, 1)), 0, 0);
            idle_check(0);
        end

        frame(8'hC3, 16'd4, 1'b0, 0, 0);
        frame(8'h5A, 16'd4, 1'b0, 0, 0);
        idle_check(0);

        frame(8'h36, 16'd8, 1'b0, 0, 30);
        idle_check(0);

        din      = 8'h08;
        baud_div = 16'd4;
        two_stop = 1'b0;
        start0   = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (k == 17) chk("rst_mid_bit3", tx0, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx",    tx0,    1);
        chk("abort_busy",  busy0,  0);
        chk("abort_ready", ready0, 1);
        chk("abort_done",  done0,  0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort_no_done", done0, 0);
            chk("abort_line",    tx0,   1);
        end
        frame(8'h81, 16'd4, 1'b0, 0, 0);
        idle_check(0);

        frame(8'h07, 16'd10, 1'b1, 2, 0);
        idle_check(2);
        frame(8'h07, 16'd0, 1'b0, 2, 0);
        idle_check(2);
        frame(8'hA5, 16'd0, 1'b1, 0, 0);
        idle_check(0);
        frame(8'h5A, 16'd0, 1'b0, 2, 0);
        frame(8'h3C, 16'd0, 1'b1, 2, 0);
        frame(8'hE1, 16'd3, 1'b0, 2, 0);
        idle_check(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
